// File: rtl/neuai_led_pkg.sv
// Shared types and constants for the LED key/mode control slice.
package neuai_led_pkg;

  localparam int PERIOD_W = 11;
  localparam logic [1:0] SPEED_RESET = 2'd2;

  typedef enum logic [1:0] {
    DB_UP        = 2'd0,
    DB_CONF_DOWN = 2'd1,
    DB_DOWN      = 2'd2,
    DB_CONF_UP   = 2'd3
  } db_state_t;

  // Breath half-period doubles with every speed step.
  function automatic logic [PERIOD_W-1:0] speed_to_period(input logic [1:0] speed);
    logic [PERIOD_W-1:0] period;
    case (speed)
      2'd0:    period = 11'd250;
      2'd1:    period = 11'd500;
      2'd2:    period = 11'd1000;
      default: period = 11'd2000;
    endcase
    return period;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key synchronizer + debounce FSM with press pulse and, when
// LONG_PRESS_EN is defined, a one-shot long-press pulse.
module key_debounce
  import neuai_led_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic w_clk_1ms,
  input  logic w_rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic long_press
);

  if (DEBOUNCE_MS < 2 || DEBOUNCE_MS > 255 || LONG_MS <= DEBOUNCE_MS || LONG_MS > 4095) begin : g_bad_params
    $error("key_debounce: DEBOUNCE_MS or LONG_MS out of range");
  end

  // The entry sample into a confirm state counts as the first stable sample.
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_MS - 2);

  logic [1:0] sync;
  logic       pressed;
  db_state_t  state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       press_next;

  // Synchronizer stores the inverted key so its reset value means "released".
  always_ff @(posedge w_clk_1ms or negedge w_rst) begin
    if (!w_rst) sync <= 2'b00;
    else        sync <= {sync[0], ~key_n};
  end

  assign pressed = sync[1];

  always_ff @(posedge w_clk_1ms or negedge w_rst) begin
    if (!w_rst) begin
      state <= DB_UP;
      cnt   <= 8'd0;
      press <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      press <= press_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    press_next = 1'b0;
    case (state)
      DB_UP: begin
        if (pressed) begin
          state_next = DB_CONF_DOWN;
          cnt_next   = 8'd0;
        end
      end
      DB_CONF_DOWN: begin
        if (!pressed) begin
          state_next = DB_UP;
        end else if (cnt == DEB_LAST) begin
          state_next = DB_DOWN;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      DB_DOWN: begin
        if (!pressed) begin
          state_next = DB_CONF_UP;
          cnt_next   = 8'd0;
        end
      end
      DB_CONF_UP: begin
        if (pressed) begin
          state_next = DB_DOWN;
        end else if (cnt == DEB_LAST) begin
          state_next = DB_UP;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: state_next = DB_UP;
    endcase
  end

  assign level = (state == DB_DOWN) || (state == DB_CONF_UP);

`ifdef LONG_PRESS_EN
  localparam logic [11:0] LONG_LAST = 12'(LONG_MS - 1);

  logic [11:0] hold;
  logic        fired;

  // Hold time starts at the press pulse; one shot until the key is back up.
  always_ff @(posedge w_clk_1ms or negedge w_rst) begin
    if (!w_rst) begin
      hold       <= 12'd0;
      fired      <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!level) begin
        hold  <= 12'd0;
        fired <= 1'b0;
      end else if (!fired) begin
        if (hold == LONG_LAST) begin
          long_press <= 1'b1;
          fired      <= 1'b1;
        end else begin
          hold <= hold + 12'd1;
        end
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/key_mode_ctrl.sv
// Three debounced keys driving breath speed and enable; optional long-press
// restore of defaults is built when LONG_PRESS_EN is defined.
module key_mode_ctrl
  import neuai_led_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic                w_clk_1ms,
  input  logic                w_rst,
  input  logic [2:0]          w_key_in,
  output logic [2:0]          o_level,
  output logic [2:0]          o_press,
  output logic [2:0]          o_long,
  output logic [1:0]          o_speed_sel,
  output logic [PERIOD_W-1:0] o_period_ms,
  output logic                o_breath_en
);

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .LONG_MS    (LONG_MS)
    ) u_key (
      .w_clk_1ms (w_clk_1ms),
      .w_rst     (w_rst),
      .key_n     (w_key_in[i]),
      .level     (o_level[i]),
      .press     (o_press[i]),
      .long_press(o_long[i])
    );
  end

  // A long press on key2 overrides any same-cycle speed step.
  always_ff @(posedge w_clk_1ms or negedge w_rst) begin
    if (!w_rst) begin
      o_speed_sel <= SPEED_RESET;
      o_period_ms <= speed_to_period(SPEED_RESET);
      o_breath_en <= 1'b1;
    end else begin
      o_period_ms <= speed_to_period(o_speed_sel);
      if (o_long[2]) begin
        o_speed_sel <= SPEED_RESET;
        o_breath_en <= 1'b1;
      end else begin
        if (o_press[0] && !o_press[1] && o_speed_sel != 2'd3)
          o_speed_sel <= o_speed_sel + 2'd1;
        else if (o_press[1] && !o_press[0] && o_speed_sel != 2'd0)
          o_speed_sel <= o_speed_sel - 2'd1;
        if (o_press[2])
          o_breath_en <= ~o_breath_en;
      end
    end
  end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed self-checking bench for key_mode_ctrl (DEBOUNCE_MS=20, LONG_MS=1000).
module tb_key_mode_ctrl;

  logic        w_clk_1ms = 1'b0;
  logic        w_rst;
  logic [2:0]  w_key_in;
  logic [2:0]  o_level, o_press, o_long;
  logic [1:0]  o_speed_sel;
  logic [10:0] o_period_ms;
  logic        o_breath_en;

  int checks = 0;
  int errors = 0;
  int cyc;
  int press_first [3];
  int press_cnt   [3];
  int long_first  [3];
  int long_cnt    [3];
  bit level_seen  [3];

  always #5 w_clk_1ms = ~w_clk_1ms;

  key_mode_ctrl #(.DEBOUNCE_MS(20), .LONG_MS(1000)) dut (
    .w_clk_1ms  (w_clk_1ms),
    .w_rst      (w_rst),
    .w_key_in   (w_key_in),
    .o_level    (o_level),
    .o_press    (o_press),
    .o_long     (o_long),
    .o_speed_sel(o_speed_sel),
    .o_period_ms(o_period_ms),
    .o_breath_en(o_breath_en)
  );

  task automatic clear_counts();
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      press_first[i] = -1;
      press_cnt[i]   = 0;
      long_first[i]  = -1;
      long_cnt[i]    = 0;
      level_seen[i]  = 1'b0;
    end
  endtask

  // Advance n clock cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge w_clk_1ms);
      #1;
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (o_press[i] === 1'b1) begin
          if (press_first[i] < 0) press_first[i] = cyc;
          press_cnt[i]++;
        end
        if (o_long[i] === 1'b1) begin
          if (long_first[i] < 0) long_first[i] = cyc;
          long_cnt[i]++;
        end
        if (o_level[i] === 1'b1) level_seen[i] = 1'b1;
      end
    end
  endtask

  task automatic press_key(input logic [2:0] mask);
    w_key_in = ~mask;
    run(40);
    w_key_in = 3'b111;
    run(40);
  endtask

  task automatic test_reset();
    w_rst    = 1'b0;
    w_key_in = 3'b111;
    clear_counts();
    repeat (3) @(posedge w_clk_1ms);
    #1;
    checks++; if (o_level !== 3'b000) begin errors++; $display("[TB] FAIL reset_level: got %b expected %b", o_level, 3'b000); end
    checks++; if (o_press !== 3'b000) begin errors++; $display("[TB] FAIL reset_press: got %b expected %b", o_press, 3'b000); end
    checks++; if (o_long !== 3'b000) begin errors++; $display("[TB] FAIL reset_long: got %b expected %b", o_long, 3'b000); end
    checks++; if (o_speed_sel !== 2'd2) begin errors++; $display("[TB] FAIL reset_speed: got %0d expected 2", o_speed_sel); end
    checks++; if (o_period_ms !== 11'd1000) begin errors++; $display("[TB] FAIL reset_period: got %0d expected 1000", o_period_ms); end
    checks++; if (o_breath_en !== 1'b1) begin errors++; $display("[TB] FAIL reset_breath: got %b expected 1", o_breath_en); end
    w_rst = 1'b1;
    run(30);
    checks++; if (press_cnt[0] + press_cnt[1] + press_cnt[2] != 0) begin errors++; $display("[TB] FAIL idle_after_reset_press: got %0d pulses expected 0", press_cnt[0] + press_cnt[1] + press_cnt[2]); end
    checks++; if (level_seen[0] | level_seen[1] | level_seen[2]) begin errors++; $display("[TB] FAIL idle_after_reset_level: got level activity expected none"); end
  endtask

  task automatic test_clean_press();
    clear_counts();
    w_key_in = 3'b110;
    run(23);
    checks++; if (press_first[0] != 22) begin errors++; $display("[TB] FAIL clean_press_cycle: got %0d expected 22", press_first[0]); end
    checks++; if (o_speed_sel !== 2'd3) begin errors++; $display("[TB] FAIL clean_speed: got %0d expected 3", o_speed_sel); end
    checks++; if (o_period_ms !== 11'd1000) begin errors++; $display("[TB] FAIL clean_period_lag: got %0d expected 1000", o_period_ms); end
    run(77);
    checks++; if (o_period_ms !== 11'd2000) begin errors++; $display("[TB] FAIL clean_period: got %0d expected 2000", o_period_ms); end
    checks++; if (press_cnt[0] != 1) begin errors++; $display("[TB] FAIL clean_press_count: got %0d expected 1", press_cnt[0]); end
    checks++; if (o_level !== 3'b001) begin errors++; $display("[TB] FAIL clean_level_held: got %b expected 001", o_level); end
    w_key_in = 3'b111;
    run(40);
    checks++; if (o_level !== 3'b000) begin errors++; $display("[TB] FAIL clean_level_released: got %b expected 000", o_level); end
    checks++; if (press_cnt[0] != 1) begin errors++; $display("[TB] FAIL clean_release_press: got %0d expected 1", press_cnt[0]); end
  endtask

  task automatic test_glitch();
    clear_counts();
    w_key_in = 3'b101;
    run(15);
    w_key_in = 3'b111;
    run(40);
    checks++; if (press_cnt[1] != 0) begin errors++; $display("[TB] FAIL glitch_press: got %0d expected 0", press_cnt[1]); end
    checks++; if (level_seen[1]) begin errors++; $display("[TB] FAIL glitch_level: got level 1 expected 0"); end
    checks++; if (o_speed_sel !== 2'd3) begin errors++; $display("[TB] FAIL glitch_speed: got %0d expected 3", o_speed_sel); end
    clear_counts();
    w_key_in = 3'b101;
    run(5);
    w_key_in = 3'b111;
    run(5);
    w_key_in = 3'b101;
    run(100);
    checks++; if (press_cnt[1] != 1) begin errors++; $display("[TB] FAIL bounce_count: got %0d expected 1", press_cnt[1]); end
    checks++; if (press_first[1] != 32) begin errors++; $display("[TB] FAIL bounce_cycle: got %0d expected 32", press_first[1]); end
    checks++; if (o_speed_sel !== 2'd2) begin errors++; $display("[TB] FAIL bounce_speed: got %0d expected 2", o_speed_sel); end
    w_key_in = 3'b111;
    run(40);
  endtask

  task automatic test_saturation();
    clear_counts();
    for (int n = 0; n < 3; n++) press_key(3'b010);
    checks++; if (o_speed_sel !== 2'd0) begin errors++; $display("[TB] FAIL sat_low_speed: got %0d expected 0", o_speed_sel); end
    checks++; if (o_period_ms !== 11'd250) begin errors++; $display("[TB] FAIL sat_low_period: got %0d expected 250", o_period_ms); end
    checks++; if (press_cnt[1] != 3) begin errors++; $display("[TB] FAIL sat_low_count: got %0d expected 3", press_cnt[1]); end
    press_key(3'b010);
    checks++; if (o_speed_sel !== 2'd0) begin errors++; $display("[TB] FAIL sat_low_hold: got %0d expected 0", o_speed_sel); end
    press_key(3'b001);
    checks++; if (o_speed_sel !== 2'd1) begin errors++; $display("[TB] FAIL step_up_speed: got %0d expected 1", o_speed_sel); end
    clear_counts();
    press_key(3'b011);
    checks++; if (press_first[0] != 22 || press_first[1] != 22) begin errors++; $display("[TB] FAIL both_cycle: got %0d/%0d expected 22/22", press_first[0], press_first[1]); end
    checks++; if (o_speed_sel !== 2'd1) begin errors++; $display("[TB] FAIL both_speed: got %0d expected 1", o_speed_sel); end
    checks++; if (o_period_ms !== 11'd500) begin errors++; $display("[TB] FAIL both_period: got %0d expected 500", o_period_ms); end
    for (int n = 0; n < 3; n++) press_key(3'b001);
    checks++; if (o_speed_sel !== 2'd3) begin errors++; $display("[TB] FAIL sat_high_speed: got %0d expected 3", o_speed_sel); end
    checks++; if (o_period_ms !== 11'd2000) begin errors++; $display("[TB] FAIL sat_high_period: got %0d expected 2000", o_period_ms); end
  endtask

  task automatic test_toggle();
    press_key(3'b100);
    checks++; if (o_breath_en !== 1'b0) begin errors++; $display("[TB] FAIL toggle_first: got %b expected 0", o_breath_en); end
    press_key(3'b100);
    checks++; if (o_breath_en !== 1'b1) begin errors++; $display("[TB] FAIL toggle_second: got %b expected 1", o_breath_en); end
  endtask

  task automatic test_reset_mid_press();
    clear_counts();
    w_key_in = 3'b110;
    run(13);
    checks++; if (press_cnt[0] != 0) begin errors++; $display("[TB] FAIL mid_pre_reset_press: got %0d expected 0", press_cnt[0]); end
    w_rst = 1'b0;
    #1;
    checks++; if (o_speed_sel !== 2'd2) begin errors++; $display("[TB] FAIL mid_reset_speed: got %0d expected 2", o_speed_sel); end
    checks++; if (o_period_ms !== 11'd1000) begin errors++; $display("[TB] FAIL mid_reset_period: got %0d expected 1000", o_period_ms); end
    checks++; if (o_level !== 3'b000 || o_press !== 3'b000) begin errors++; $display("[TB] FAIL mid_reset_keys: got level %b press %b expected 000/000", o_level, o_press); end
    run(3);
    w_rst = 1'b1;
    clear_counts();
    run(60);
    checks++; if (press_first[0] != 22) begin errors++; $display("[TB] FAIL mid_requal_cycle: got %0d expected 22", press_first[0]); end
    checks++; if (press_cnt[0] != 1) begin errors++; $display("[TB] FAIL mid_requal_count: got %0d expected 1", press_cnt[0]); end
    checks++; if (o_speed_sel !== 2'd3) begin errors++; $display("[TB] FAIL mid_requal_speed: got %0d expected 3", o_speed_sel); end
    w_key_in = 3'b111;
    run(40);
  endtask

  task automatic test_long_press();
`ifdef LONG_PRESS_EN
    for (int n = 0; n < 3; n++) press_key(3'b010);
    checks++; if (o_speed_sel !== 2'd0) begin errors++; $display("[TB] FAIL long_setup_speed: got %0d expected 0", o_speed_sel); end
    clear_counts();
    w_key_in = 3'b011;
    run(500);
    checks++; if (press_first[2] != 22) begin errors++; $display("[TB] FAIL long_press_cycle: got %0d expected 22", press_first[2]); end
    checks++; if (o_breath_en !== 1'b0) begin errors++; $display("[TB] FAIL long_mid_breath: got %b expected 0", o_breath_en); end
    run(700);
    checks++; if (long_first[2] != 1022) begin errors++; $display("[TB] FAIL long_cycle: got %0d expected 1022", long_first[2]); end
    checks++; if (long_cnt[2] != 1) begin errors++; $display("[TB] FAIL long_count: got %0d expected 1", long_cnt[2]); end
    checks++; if (o_speed_sel !== 2'd2) begin errors++; $display("[TB] FAIL long_speed: got %0d expected 2", o_speed_sel); end
    checks++; if (o_breath_en !== 1'b1) begin errors++; $display("[TB] FAIL long_breath: got %b expected 1", o_breath_en); end
`else
    clear_counts();
    w_key_in = 3'b011;
    run(1200);
    checks++; if (long_cnt[0] + long_cnt[1] + long_cnt[2] != 0) begin errors++; $display("[TB] FAIL nolong_pulses: got %0d expected 0", long_cnt[0] + long_cnt[1] + long_cnt[2]); end
    checks++; if (press_cnt[2] != 1) begin errors++; $display("[TB] FAIL nolong_press: got %0d expected 1", press_cnt[2]); end
    checks++; if (o_breath_en !== 1'b0) begin errors++; $display("[TB] FAIL nolong_breath: got %b expected 0", o_breath_en); end
`endif
    w_key_in = 3'b111;
    run(40);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_saturation();
    test_toggle();
    test_reset_mid_press();
    test_long_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_mode_ctrl.md
KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_MS, default 20: stable-level time in ms required to accept a key edge (range 2..255).
REQ-002 SHALL have parameter LONG_MS, default 1000: hold time in ms for a long press (range DEBOUNCE_MS+1..4095).
REQ-003 SHALL have port w_clk_1ms  in  1: 1 kHz clock.
REQ-004 SHALL have port w_rst  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port w_key_in  in  3: raw keys, active-low, asynchronous to w_clk_1ms; bit0 = speed up, bit1 = speed down, bit2 = breath enable toggle.
REQ-006 SHALL have port o_level  out  3: debounced key state, 1 = pressed.
REQ-007 SHALL have port o_press  out  3: one-cycle pulse per accepted press.
REQ-008 SHALL have port o_long  out  3: one-cycle pulse when a press has been held LONG_MS.
REQ-009 SHALL have port o_speed_sel  out  2: breath speed index 0..3.
REQ-010 SHALL have port o_period_ms  out  11: breath half-period in ms, feeding the downstream breath generator.
REQ-011 SHALL have port o_breath_en  out  1: 1 = LED breathing, 0 = LED held off.

Function
REQ-012 SHALL pass each w_key_in bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL run one 4-state debounce FSM per key: UP, CONF_DOWN, DOWN, CONF_UP.
REQ-014 UP -> CONF_DOWN when the synchronized key is low; the debounce counter is cleared on entry.
REQ-015 CONF_DOWN -> DOWN after DEBOUNCE_MS consecutive low samples; any high sample returns the FSM to UP.
REQ-016 DOWN -> CONF_UP on a high sample; CONF_UP -> UP after DEBOUNCE_MS consecutive high samples; any low sample returns the FSM to DOWN.
REQ-017 o_level SHALL be 1 in states DOWN and CONF_UP only.
REQ-018 o_press SHALL pulse for one cycle on the CONF_DOWN -> DOWN transition; latency from a clean press edge is 2 + DEBOUNCE_MS cycles.
REQ-019 A glitch shorter than DEBOUNCE_MS SHALL produce no o_press and no o_level change.
REQ-020 o_press[0] SHALL increment o_speed_sel, saturating at 3; o_press[1] SHALL decrement it, saturating at 0.
REQ-021 Simultaneous o_press[0] and o_press[1] in the same cycle SHALL leave o_speed_sel unchanged.
REQ-022 o_press[2] SHALL toggle o_breath_en.
REQ-023 o_period_ms SHALL be registered from o_speed_sel: 0 -> 250, 1 -> 500, 2 -> 1000, 3 -> 2000; it updates one cycle after o_speed_sel.
REQ-024 All state SHALL update on posedge w_clk_1ms only.

Reset
REQ-025 On w_rst = 0, all FSMs SHALL go to UP, all counters and synchronizer flops to 0, o_level = 0, o_press = 0, o_long = 0, o_speed_sel = 2, o_period_ms = 1000, o_breath_en = 1.
REQ-026 Reset asserted mid-press SHALL discard the press; after release of reset, a still-held key SHALL be re-qualified from UP with no pulse lost or duplicated.

Configuration
REQ-027 With LONG_PRESS_EN defined, each key SHALL have a hold counter running in DOWN/CONF_UP.
REQ-028 With LONG_PRESS_EN defined, o_long SHALL pulse once when the hold reaches LONG_MS after o_press; there is no repeat until the key returns to UP.
REQ-029 With LONG_PRESS_EN defined, o_long[2] SHALL restore o_speed_sel = 2 and o_breath_en = 1; when o_long[2] and o_press[0]/[1] occur in the same cycle, o_long[2] wins.
REQ-030 Without LONG_PRESS_EN, o_long SHALL be constant 0 and no hold counters SHALL be synthesized.

Structure
REQ-031 Package neuai_led_pkg SHALL hold the debounce state encoding, the speed-to-period table, SPEED_RESET = 2 and the 11-bit period width.
REQ-032 Sub-module key_debounce SHALL contain the synchronizer, FSM, counters and the o_level/o_press/o_long logic for one key; key_mode_ctrl SHALL instantiate it 3 times plus the mode registers.

Verification
REQ-033 Clean press: hold key0 low 100 ms -> o_press[0] pulses at cycle 22; o_speed_sel goes 2 -> 3; o_period_ms goes 1000 -> 2000.
REQ-034 Glitch: key1 low 15 ms then high -> no o_press, o_level stays 0; bounce of 5 ms low/high before a stable press -> exactly one pulse.
REQ-035 Saturation: 3 presses of key1 -> o_speed_sel = 0 and o_period_ms = 250; a 4th press -> unchanged; key0 and key1 pressed in the same cycle -> unchanged.
REQ-036 Toggle: 2 presses of key2 -> o_breath_en goes 1 -> 0 -> 1.
REQ-037 Reset mid-press: w_rst low at cycle 10 of CONF_DOWN -> outputs at reset values; key held through reset release -> a single o_press 2 + DEBOUNCE_MS cycles after release.
REQ-038 LONG_PRESS_EN: from speed 0, hold key2 1200 ms -> o_press[2] at cycle 22 (breath_en -> 0), o_long[2] at cycle 1022, o_speed_sel = 2, o_breath_en = 1; without the macro, o_long stays 0.
